pulse_btn_cond: RTL and testbench
=================================

// Module: pulse_btn_cond
// PURPOSE
//  Front end for the alarm clock/calendar datapath. Divides the board clock
//  down to the 1-per-second Pulse that clocks all time/date/alarm counters.
//  Synchronises and debounces the raw manual buttons (Timeset, Alarmset,
//  Minadv, Hrsadv, Alarmon, Dayadv, Dateadv, Monthadv).
//  Outputs are aligned to Pulse, so every button level is stable across
//  each Pulse rising edge.
// PARAMETERS
//  TICK_DIV  1000  clk cycles per Pulse period; even, >=4
//  DEB_CYC   20    consecutive stable cycles needed to accept a level change; >=1
//  NBTN      8     number of button inputs
// PORTS
//  clk      in   1     board clock
//  Reset    in   1     reset, synchronous, active-low
//  btn_raw  in   NBTN  asynchronous raw button levels, 1 = pressed
//  Pulse    out  1     ~50% duty square wave, period TICK_DIV clk; counter clock
//  tick     out  1     one-clk strobe, high in the cycle Pulse rises
//  btn_db   out  NBTN  debounced button levels, clk domain
//  btn_out  out  NBTN  Pulse-aligned button levels fed to the counter enables
// BEHAVIOUR
//  Reset (Reset==0 at posedge clk)
//   - div_cnt=0, Pulse=0, tick=0, btn_db=0, btn_out=0.
//   - Sync flops cleared; every debouncer in STABLE_LO with its counter at 0.
//   - Reset asserted mid-operation aborts everything on that edge.
//  Divider
//   - div_cnt runs 0..TICK_DIV-1 and then wraps to 0.
//   - On the wrap edge (TICK_DIV-1 -> 0): Pulse<=1 and tick<=1 for exactly one cycle.
//   - On the edge where div_cnt goes TICK_DIV/2-1 -> TICK_DIV/2: Pulse<=0 (the "fall edge").
//   - Timing after reset release: the first tick/Pulse rise is registered on the
//     TICK_DIV-th clk edge. Pulse high time = low time = TICK_DIV/2 clk.
//  Synchroniser
//   - Two flops per bit: btn_raw -> s1 -> s2.
//   - Raw-to-s2 latency is 2 clk.
//  Debouncer (one FSM per bit, fed by s2)
//   - States: STABLE_LO, CHK_HI, STABLE_HI, CHK_LO.
//   - STABLE_LO: if s2==1 go to CHK_HI with cnt=1.
//   - CHK_HI: if s2==1, cnt++. If s2==0, return to STABLE_LO with cnt=0.
//     When cnt reaches DEB_CYC, go to STABLE_HI and set btn_db=1.
//   - STABLE_HI / CHK_LO: mirror image of the above, ending with btn_db=0.
//   - Any bounce during a CHK state restarts qualification from scratch.
//   - Total latency raw edge -> btn_db = 2 + DEB_CYC clk for a clean edge.
//   - cnt width is $clog2(DEB_CYC+1); it saturates and cannot wrap.
//  Pulse alignment
//   - btn_out is loaded only on the fall edge (see Divider), never at any other time.
//   - Result: btn_out is constant for TICK_DIV/2 clk before and after every Pulse rise.
//  Simultaneous events
//   - All bits are fully independent.
//   - If a btn_db change and a fall edge land in the same cycle, btn_out takes
//     the pre-change btn_db value. The new value is picked up on the next fall edge.
// CONFIGURATION
//  BTN_LATCH_EN (macro)
//   - Defined: each bit has a sticky flag, set when btn_db rises. On every fall
//     edge, btn_out <= btn_db | flag and the flag is cleared. If a rise and a fall
//     edge coincide, the flag stays set (not cleared). Effect: a debounced press
//     shorter than one Pulse period still produces btn_out=1 for exactly one period.
//     The flag is cleared by Reset.
//   - Undefined: btn_out <= btn_db on each fall edge; no flags are synthesised.
//     A press that starts and ends between two fall edges is lost.
// TESTING
//  Run every directed test with TICK_DIV=8 and DEB_CYC=3, under both macro settings.
//  1. Reset held 5 clk, then released
//     -> tick is high on clk edges 8, 16, 24. Pulse is high on cycles 8-11 and
//        low on 12-15. All outputs read 0 while reset is held.
//  2. btn_raw[2] clean 0->1 at cycle 20
//     -> btn_db[2]=1 at cycle 25. btn_out[2]=1 from the next fall edge (cycle 28).
//  3. btn_raw[0] bounces 1,0,1,0 on alternate clk, then stays at 1
//     -> btn_db[0] rises only after 3 consecutive stable samples.
//        No glitch ever appears on btn_db[0].
//  4. 4-clk debounced press of btn[3] lying entirely between two fall edges
//     -> with BTN_LATCH_EN: btn_out[3]=1 for exactly one period (8 clk).
//        Without it: btn_out[3] stays 0.
//  5. Reset driven low mid-count while btn_db=8'hFF
//     -> on the next edge all outputs are 0 and div_cnt is 0.
//        The first tick comes TICK_DIV clk after release.
//  6. Scoreboard on a random btn_raw stream
//     -> btn_out changes only in the cycle after a Pulse fall edge.

Source files
------------

// File: rtl/pulse_btn_cond.sv
// -----------------------------------------------------------------------------
// pulse_btn_cond
//   Front end for the alarm clock/calendar datapath.
//   - Divides clk down to Pulse, the counter clock: a ~50% square wave with a
//     period of TICK_DIV clk. tick is a one-clk strobe in the cycle Pulse rises.
//   - Synchronises (two flops) and debounces (one 4-state FSM per bit) the raw
//     manual buttons.
//   - Re-times the debounced levels onto btn_out on the Pulse fall edge only,
//     so btn_out is stable for TICK_DIV/2 clk on both sides of each Pulse rise.
//
// Parameters
//   TICK_DIV  clk cycles per Pulse period (even, >= 4)
//   DEB_CYC   consecutive stable samples needed to accept a level change (>= 1)
//   NBTN      number of button inputs
//
// Ports
//   clk      in   board clock
//   Reset    in   synchronous, active-low reset
//   btn_raw  in   [NBTN] asynchronous raw button levels, 1 = pressed
//   Pulse    out  counter clock, period TICK_DIV clk
//   tick     out  one-clk strobe, high in the cycle Pulse rises
//   btn_db   out  [NBTN] debounced levels, clk domain
//   btn_out  out  [NBTN] Pulse-aligned levels for the counter enables
//
// Configuration macro
//   BTN_LATCH_EN  when defined, each bit gets a sticky flag set on a debounced
//                 rise, so a press shorter than one Pulse period still shows
//                 on btn_out for exactly one period. Undefined: no flags.
// -----------------------------------------------------------------------------
module pulse_btn_cond #(
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned DEB_CYC  = 20,
  parameter int unsigned NBTN     = 8
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic [NBTN-1:0] btn_raw,
  output logic            Pulse,
  output logic            tick,
  output logic [NBTN-1:0] btn_db,
  output logic [NBTN-1:0] btn_out
);

  localparam int unsigned DIV_W = $clog2(TICK_DIV);
  localparam int unsigned CNT_W = $clog2(DEB_CYC + 1);

  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF_M1 = DIV_W'(TICK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    STABLE_LO,
    CHK_HI,
    STABLE_HI,
    CHK_LO
  } deb_state_t;

  // ---------------------------------------------------------------------------
  // Divider
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] r_div_cnt;
  logic             r_pulse;
  logic             r_tick;
  logic             w_wrap;
  logic             w_fall;

  assign w_wrap = (r_div_cnt == DIV_LAST);
  assign w_fall = (r_div_cnt == DIV_HALF_M1);

  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_div_cnt <= '0;
      r_pulse   <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_tick <= w_wrap;
      if (w_wrap) begin
        r_div_cnt <= '0;
        r_pulse   <= 1'b1;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
        if (w_fall) begin
          r_pulse <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser
  // ---------------------------------------------------------------------------
  logic [NBTN-1:0] r_s1;
  logic [NBTN-1:0] r_s2;

  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= btn_raw;
      r_s2 <= r_s1;
    end
  end

  // ---------------------------------------------------------------------------
  // Debouncers, one FSM per bit
  // ---------------------------------------------------------------------------
  deb_state_t       r_state     [NBTN];
  logic [CNT_W-1:0] r_cnt       [NBTN];
  deb_state_t       w_state_nxt [NBTN];
  logic [CNT_W-1:0] w_cnt_nxt   [NBTN];
  logic [NBTN-1:0]  r_btn_db;
  logic [NBTN-1:0]  w_db_nxt;

  always_ff @(posedge clk) begin
    if (!Reset) begin
      for (int unsigned i = 0; i < NBTN; i++) begin
        r_state[i] <= STABLE_LO;
        r_cnt[i]   <= '0;
      end
      r_btn_db <= '0;
    end else begin
      for (int unsigned i = 0; i < NBTN; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
      r_btn_db <= w_db_nxt;
    end
  end

  // The sample that leaves a STABLE state counts as the first of DEB_CYC, so
  // the level is accepted on the edge taking the DEB_CYC-th matching sample.
  always_comb begin
    w_db_nxt = r_btn_db;
    for (int unsigned i = 0; i < NBTN; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      unique case (r_state[i])
        STABLE_LO: begin
          if (r_s2[i]) begin
            if (DEB_CYC == 1) begin
              w_state_nxt[i] = STABLE_HI;
              w_cnt_nxt[i]   = '0;
              w_db_nxt[i]    = 1'b1;
            end else begin
              w_state_nxt[i] = CHK_HI;
              w_cnt_nxt[i]   = CNT_ONE;
            end
          end
        end
        CHK_HI: begin
          if (!r_s2[i]) begin
            w_state_nxt[i] = STABLE_LO;
            w_cnt_nxt[i]   = '0;
          end else if (r_cnt[i] == CNT_LAST) begin
            w_state_nxt[i] = STABLE_HI;
            w_cnt_nxt[i]   = '0;
            w_db_nxt[i]    = 1'b1;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!r_s2[i]) begin
            if (DEB_CYC == 1) begin
              w_state_nxt[i] = STABLE_LO;
              w_cnt_nxt[i]   = '0;
              w_db_nxt[i]    = 1'b0;
            end else begin
              w_state_nxt[i] = CHK_LO;
              w_cnt_nxt[i]   = CNT_ONE;
            end
          end
        end
        CHK_LO: begin
          if (r_s2[i]) begin
            w_state_nxt[i] = STABLE_HI;
            w_cnt_nxt[i]   = '0;
          end else if (r_cnt[i] == CNT_LAST) begin
            w_state_nxt[i] = STABLE_LO;
            w_cnt_nxt[i]   = '0;
            w_db_nxt[i]    = 1'b0;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
          end
        end
        default: begin
          w_state_nxt[i] = STABLE_LO;
          w_cnt_nxt[i]   = '0;
          w_db_nxt[i]    = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Pulse alignment
  // ---------------------------------------------------------------------------
  logic [NBTN-1:0] w_out_src;
  logic [NBTN-1:0] r_btn_out;

`ifdef BTN_LATCH_EN
  logic [NBTN-1:0] r_flag;
  logic [NBTN-1:0] w_rise;

  assign w_rise = w_db_nxt & ~r_btn_db;

  // A rise landing on the fall edge is kept: btn_out takes the old level this
  // time, and the flag carries the press to the next fall edge.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_flag <= '0;
    end else begin
      r_flag <= w_rise | (w_fall ? '0 : r_flag);
    end
  end

  assign w_out_src = r_btn_db | r_flag;
`else
  assign w_out_src = r_btn_db;
`endif

  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_btn_out <= '0;
    end else if (w_fall) begin
      r_btn_out <= w_out_src;
    end
  end

  assign Pulse   = r_pulse;
  assign tick    = r_tick;
  assign btn_db  = r_btn_db;
  assign btn_out = r_btn_out;

endmodule

// File: tb/tb_pulse_btn_cond.sv
module tb_pulse_btn_cond;

  localparam int TD = 8;
  localparam int DC = 3;
`ifdef BTN_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic       clk;
  logic       Reset;
  logic [7:0] btn_raw;
  logic       Pulse;
  logic       tick;
  logic [7:0] btn_db;
  logic [7:0] btn_out;

  pulse_btn_cond #(
    .TICK_DIV(TD),
    .DEB_CYC (DC),
    .NBTN    (8)
  ) dut (
    .clk    (clk),
    .Reset  (Reset),
    .btn_raw(btn_raw),
    .Pulse  (Pulse),
    .tick   (tick),
    .btn_db (btn_db),
    .btn_out(btn_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: edge count since release, delay line for the
  // synchroniser, and a run-length rule for debouncing (a level is accepted
  // once DC consecutive synchronised samples disagree with the current level).
  int         m_n;
  logic [7:0] m_s1, m_s2, m_db, m_out, m_flag;
  int         m_run [8];
  logic       m_tick, m_pulse, m_last_fall, m_last_rst;

  task automatic model_edge(input logic r, input logic [7:0] raw);
    logic [7:0] nd;
    int         ph;
    logic       fall;
    if (!r) begin
      m_n = 0; m_s1 = '0; m_s2 = '0; m_db = '0; m_out = '0; m_flag = '0;
      for (int b = 0; b < 8; b++) m_run[b] = 0;
      m_tick = 1'b0; m_pulse = 1'b0; m_last_fall = 1'b0; m_last_rst = 1'b1;
    end else begin
      m_n++;
      ph   = m_n % TD;
      fall = (ph == TD / 2);
      nd   = m_db;
      for (int b = 0; b < 8; b++) begin
        if (m_s2[b] !== m_db[b]) begin
          m_run[b]++;
          if (m_run[b] == DC) begin
            nd[b]    = m_s2[b];
            m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      if (fall) m_out = m_db | (LATCH ? m_flag : 8'h00);
      if (LATCH) m_flag = (nd & ~m_db) | (fall ? 8'h00 : m_flag);
      m_db  = nd;
      m_s2  = m_s1;
      m_s1  = raw;
      m_tick  = (ph == 0);
      m_pulse = (m_n >= TD) && (ph < TD / 2);
      m_last_fall = fall;
      m_last_rst  = 1'b0;
    end
  endtask

  task automatic check_model();
    chk("model_tick", 32'(tick), 32'(m_tick));
    chk("model_pulse", 32'(Pulse), 32'(m_pulse));
    chk("model_btn_db", 32'(btn_db), 32'(m_db));
    chk("model_btn_out", 32'(btn_out), 32'(m_out));
  endtask

  // Apply inputs, take one posedge, advance the model, sample at negedge.
  task automatic cyc(input logic r, input logic [7:0] raw);
    Reset   = r;
    btn_raw = raw;
    @(posedge clk);
    model_edge(r, raw);
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    logic       rst;
    logic [7:0] raw;
    logic       tick;
    logic       pulse;
    logic [7:0] db;
    logic [7:0] out;
  } vec_t;

  vec_t tbl [34];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] raw;
    logic [7:0] prev_out;
    logic       b0;
    logic       exp_o3;
    int         n;
    int         seq0 [12];

    Reset   = 1'b0;
    btn_raw = 8'h00;

    // Tests 1 and 2: 5 reset cycles, then cycles 1..29 after release.
    // btn_raw[2] rises in cycle 20 (sampled at edge 21).
    for (int k = 0; k < 34; k++) begin
      n = k - 4;
      tbl[k].rst   = (n >= 1);
      tbl[k].raw   = (n >= 21) ? 8'h04 : 8'h00;
      tbl[k].tick  = (n == 8) || (n == 16) || (n == 24);
      tbl[k].pulse = (n >= 8 && n <= 11) || (n >= 16 && n <= 19) || (n >= 24 && n <= 27);
      tbl[k].db    = (n >= 25) ? 8'h04 : 8'h00;
      tbl[k].out   = (n >= 28) ? 8'h04 : 8'h00;
    end

    for (int k = 0; k < 34; k++) begin
      cyc(tbl[k].rst, tbl[k].raw);
      chk($sformatf("tbl%0d_tick", k), 32'(tick), 32'(tbl[k].tick));
      chk($sformatf("tbl%0d_pulse", k), 32'(Pulse), 32'(tbl[k].pulse));
      chk($sformatf("tbl%0d_db", k), 32'(btn_db), 32'(tbl[k].db));
      chk($sformatf("tbl%0d_out", k), 32'(btn_out), 32'(tbl[k].out));
    end

    // Test 3: bounce on bit 0, then hold high. Final 1 applied at index 4,
    // accepted DC+1 edges later (index 8).
    seq0 = '{1, 0, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    for (int j = 0; j < 12; j++) begin
      cyc(1'b1, 8'h04 | 8'(seq0[j]));
      b0 = (j >= 8);
      chk($sformatf("bounce_db0_j%0d", j), 32'(btn_db[0]), 32'(b0));
    end

    // Test 4: short press on bit 3 whose debounced high lies between two fall
    // edges. First raw-high sample on an edge with phase 1; fall edges then
    // land at indices 3, 11 and 19.
    while (((m_n + 1) % TD) != 1) cyc(1'b1, 8'h05);
    for (int j = 0; j < 24; j++) begin
      cyc(1'b1, (j < 4) ? 8'h0D : 8'h05);
      chk($sformatf("short_db3_j%0d", j), 32'(btn_db[3]), 32'(j >= 4 && j <= 7));
      exp_o3 = LATCH && (j >= 11) && (j <= 18);
      chk($sformatf("short_out3_j%0d", j), 32'(btn_out[3]), 32'(exp_o3));
    end

    // Test 5: all buttons held until btn_out is 8'hFF, then reset mid-count.
    for (int j = 0; j < 20; j++) cyc(1'b1, 8'hFF);
    if (((m_n + 1) % TD) == 0) cyc(1'b1, 8'hFF);
    chk("pre_reset_db", 32'(btn_db), 32'hFF);
    chk("pre_reset_out", 32'(btn_out), 32'hFF);
    cyc(1'b0, 8'hFF);
    chk("mid_reset_all", {29'd0, Pulse, tick, 1'b0} | 32'(btn_db) | 32'(btn_out), 32'h0);
    chk("mid_reset_divcnt", 32'(dut.r_div_cnt), 32'h0);
    for (int j = 1; j <= TD; j++) begin
      cyc(1'b1, 8'hFF);
      chk($sformatf("post_reset_tick_%0d", j), 32'(tick), 32'(j == TD));
    end

    // Test 6: random stream, low-level bits bouncy, high bits slow, rare reset.
    raw      = btn_raw;
    prev_out = btn_out;
    for (int j = 0; j < 3000; j++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, (b < 4) ? 3 : 15) == 0) raw[b] = ~raw[b];
      end
      cyc(($urandom_range(0, 399) != 0), raw);
      if (btn_out !== prev_out)
        chk("out_change_at_fall", 32'(m_last_fall | m_last_rst), 32'h1);
      prev_out = btn_out;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
